// File: rtl/score_display_pkg.sv
// Shared constants and types for the scoreboard display controller.
package score_display_pkg;

    localparam logic [3:0] DIGIT_WIN  = 4'hA;
    localparam logic [3:0] DIGIT_LOSE = 4'hE;
    localparam int         CONV_STEPS = 8;

    typedef enum logic [1:0] {IDLE, CONVERT, LATCH} conv_state_e;
    typedef enum logic [1:0] {MODE_SCORE, MODE_WIN, MODE_LOSE} disp_mode_e;

    function automatic logic [7:0] clamp_score(input logic [7:0] score, input logic [7:0] max_score);
        return (score > max_score) ? max_score : score;
    endfunction

endpackage

// File: rtl/score_display_controller_bcd.sv
// Sequential double-dabble: 8-bit binary (<=99) to two BCD digits, one shift per clock.
//   state   | meaning
//   IDLE    | waiting for start
//   CONVERT | add-3/shift, one step per clock, CONV_STEPS steps
//   LATCH   | result valid on tens/ones, done=1 for this cycle; start here chains a new value
module bcd_double_dabble_seq
    import score_display_pkg::*;
(
    input  logic       clk,
    input  logic       rst_l,
    input  logic       start,
    input  logic [7:0] value,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    localparam int                STEP_W    = $clog2(CONV_STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CONV_STEPS - 1);

    conv_state_e       state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [15:0]       sr_q, sr_d;
    logic [15:0]       adj;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        sr_d    = sr_q;
        adj     = sr_q;
        if (adj[11:8] >= 4'd5)  adj[11:8]  = adj[11:8] + 4'd3;
        if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
        case (state_q)
            CONVERT: begin
                sr_d = adj << 1;
                if (step_q == LAST_STEP) state_d = LATCH;
                else                     step_d  = step_q + STEP_W'(1);
            end
            default: begin
                if (start) begin
                    sr_d    = {8'd0, value};
                    step_d  = '0;
                    state_d = CONVERT;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q <= IDLE;
            step_q  <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            sr_q    <= sr_d;
        end
    end

    assign done = (state_q == LATCH);
    assign tens = sr_q[15:12];
    assign ones = sr_q[11:8];

endmodule

// File: rtl/score_display_controller.sv
// Scoreboard sequencer: queues score conversions, selects score/win/lose codes
// and blinks the win/lose codes.
module score_display_controller
    import score_display_pkg::*;
#(
    parameter int BLINK_CLKS = 6250000,
    parameter int SCORE_MAX  = 99
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [7:0] i_Score,
    input  logic       i_Score_Valid,
    input  logic       i_Game_Win,
    input  logic       i_Game_Lose,
    output logic [3:0] o_Digit_Tens,
    output logic [3:0] o_Digit_Ones,
    output logic       o_Blank,
    output logic       o_Busy
);

    localparam int               CNT_W      = $clog2(BLINK_CLKS);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CLKS - 1);
    localparam logic [7:0]       SCORE_CAP  = 8'(SCORE_MAX);

    logic [7:0]       score_in;
    logic             eng_start, eng_done;
    logic [7:0]       eng_value;
    logic [3:0]       eng_tens, eng_ones;

    logic             busy_q, busy_d;
    logic             slot_vld_q, slot_vld_d;
    logic [7:0]       slot_val_q, slot_val_d;
    logic [3:0]       score_tens_q, score_tens_d, score_ones_q, score_ones_d;
    disp_mode_e       mode_q, mode_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blank_q, blank_d;
    logic [3:0]       digit_tens_q, digit_tens_d, digit_ones_q, digit_ones_d;

    assign score_in = clamp_score(i_Score, SCORE_CAP);

    bcd_double_dabble_seq u_bcd (
        .clk   (i_Clk),
        .rst_l (i_Rst_L),
        .start (eng_start),
        .value (eng_value),
        .done  (eng_done),
        .tens  (eng_tens),
        .ones  (eng_ones)
    );

    always_comb begin
        eng_start    = 1'b0;
        eng_value    = score_in;
        busy_d       = busy_q;
        slot_vld_d   = slot_vld_q;
        slot_val_d   = slot_val_q;
        score_tens_d = score_tens_q;
        score_ones_d = score_ones_q;

        if (!busy_q) begin
            if (i_Score_Valid) begin
                eng_start = 1'b1;
                busy_d    = 1'b1;
            end
        end else if (eng_done) begin
            score_tens_d = eng_tens;
            score_ones_d = eng_ones;
            // A valid arriving on the latch cycle is newer than the slot, so it wins.
            if (i_Score_Valid) begin
                eng_start  = 1'b1;
                slot_vld_d = 1'b0;
            end else if (slot_vld_q) begin
                eng_start  = 1'b1;
                eng_value  = slot_val_q;
                slot_vld_d = 1'b0;
            end else begin
                busy_d = 1'b0;
            end
        end else if (i_Score_Valid) begin
            slot_vld_d = 1'b1;
            slot_val_d = score_in;
        end

        if (i_Game_Lose)     mode_d = MODE_LOSE;
        else if (i_Game_Win) mode_d = MODE_WIN;
        else                 mode_d = MODE_SCORE;

        blink_cnt_d = blink_cnt_q;
        blank_d     = blank_q;
        if (mode_d != mode_q || mode_d == MODE_SCORE) begin
            blink_cnt_d = '0;
            blank_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blank_d     = ~blank_q;
        end else begin
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
        end

        case (mode_d)
            MODE_LOSE: begin digit_tens_d = DIGIT_LOSE; digit_ones_d = DIGIT_LOSE; end
            MODE_WIN:  begin digit_tens_d = DIGIT_WIN;  digit_ones_d = DIGIT_WIN;  end
            default:   begin digit_tens_d = score_tens_q; digit_ones_d = score_ones_q; end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            busy_q       <= 1'b0;
            slot_vld_q   <= 1'b0;
            slot_val_q   <= '0;
            score_tens_q <= '0;
            score_ones_q <= '0;
            mode_q       <= MODE_SCORE;
            blink_cnt_q  <= '0;
            blank_q      <= 1'b0;
            digit_tens_q <= '0;
            digit_ones_q <= '0;
        end else begin
            busy_q       <= busy_d;
            slot_vld_q   <= slot_vld_d;
            slot_val_q   <= slot_val_d;
            score_tens_q <= score_tens_d;
            score_ones_q <= score_ones_d;
            mode_q       <= mode_d;
            blink_cnt_q  <= blink_cnt_d;
            blank_q      <= blank_d;
            digit_tens_q <= digit_tens_d;
            digit_ones_q <= digit_ones_d;
        end
    end

    assign o_Digit_Tens = digit_tens_q;
    assign o_Digit_Ones = digit_ones_q;
    assign o_Blank      = blank_q;
    assign o_Busy       = busy_q;

endmodule

// File: tb/tb_score_display_controller.sv
// Bench for score_display_controller: cycle model compared every clock plus directed literal checks.
module tb_score_display_controller;

    localparam int BLINK = 4;
    localparam int LAT   = 9;

    logic       clk = 1'b0;
    logic       rst_l;
    logic [7:0] score;
    logic       score_valid, game_win, game_lose;
    logic [3:0] dig_tens, dig_ones;
    logic       blank, busy;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    score_display_controller #(.BLINK_CLKS(BLINK), .SCORE_MAX(99)) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_l),
        .i_Score       (score),
        .i_Score_Valid (score_valid),
        .i_Game_Win    (game_win),
        .i_Game_Lose   (game_lose),
        .o_Digit_Tens  (dig_tens),
        .o_Digit_Ones  (dig_ones),
        .o_Blank       (blank),
        .o_Busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: conversion is a countdown to a decimal split, blink is elapsed-time arithmetic.
    int m_tens, m_ones, m_blank, m_busy;
    int m_score, m_conv_val, m_left, m_pend_vld, m_pend_val, m_mode, m_k, m_now;

    function automatic int clamp(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    always @(posedge clk) begin
        if (!rst_l) begin
            m_tens = 0; m_ones = 0; m_blank = 0; m_busy = 0;
            m_score = 0; m_conv_val = 0; m_left = 0;
            m_pend_vld = 0; m_pend_val = 0; m_mode = 0; m_k = 0;
        end else begin
            m_now = game_lose ? 2 : (game_win ? 1 : 0);
            if (m_now != m_mode) m_k = 0;
            else                 m_k++;
            m_mode = m_now;
            if (m_now == 2)      begin m_tens = 14; m_ones = 14; end
            else if (m_now == 1) begin m_tens = 10; m_ones = 10; end
            else                 begin m_tens = m_score / 10; m_ones = m_score % 10; end
            m_blank = (m_now == 0) ? 0 : (m_k / BLINK) % 2;

            if (m_busy == 0) begin
                if (score_valid) begin
                    m_conv_val = clamp(int'(score)); m_left = LAT; m_busy = 1;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_score = m_conv_val;
                    if (score_valid) begin
                        m_conv_val = clamp(int'(score)); m_left = LAT; m_pend_vld = 0;
                    end else if (m_pend_vld != 0) begin
                        m_conv_val = m_pend_val; m_left = LAT; m_pend_vld = 0;
                    end else begin
                        m_busy = 0;
                    end
                end else if (score_valid) begin
                    m_pend_vld = 1; m_pend_val = clamp(int'(score));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_tens",  dig_tens, m_tens);
            chk("model_ones",  dig_ones, m_ones);
            chk("model_blank", blank,    m_blank);
            chk("model_busy",  busy,     m_busy);
        end
    end

    task automatic pulse(input int v);
        score = 8'(v);
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    bit bad;
    bit bad12;

    initial begin
        rst_l = 1'b0; score = '0; score_valid = 1'b0; game_win = 1'b0; game_lose = 1'b0;
        ticks(3);
        cmp_en = 1'b1;
        rst_l = 1'b1;
        ticks(1);
        chk("rst_tens", dig_tens, 0);
        chk("rst_ones", dig_ones, 0);
        chk("rst_blank", blank, 0);
        chk("rst_busy", busy, 0);

        pulse(37);
        ticks(1);
        chk("busy_t1", busy, 1);
        ticks(8);
        chk("busy_t9", busy, 0);
        chk("tens_t9_old", dig_tens, 0);
        ticks(1);
        chk("tens_37", dig_tens, 3);
        chk("ones_37", dig_ones, 7);

        pulse(150);
        ticks(10);
        chk("tens_clamp", dig_tens, 9);
        chk("ones_clamp", dig_ones, 9);

        pulse(0);
        ticks(10);
        chk("tens_zero", dig_tens, 0);
        chk("ones_zero", dig_ones, 0);

        // Pending slot: 45 at T0, 12 at T3, 58 at T5.
        pulse(45);
        ticks(2);
        pulse(12);
        ticks(1);
        pulse(58);
        bad = 1'b0; bad12 = 1'b0;
        for (int t = 6; t <= 19; t++) begin
            @(negedge clk);
            if (t <= 17 && busy !== 1'b1) bad = 1'b1;
            if (dig_tens == 4'd1 && dig_ones == 4'd2) bad12 = 1'b1;
            if (t == 10) begin
                chk("tens_45", dig_tens, 4);
                chk("ones_45", dig_ones, 5);
            end
            if (t == 18) chk("ones_t18_still_45", dig_ones, 5);
        end
        chk("tens_58", dig_tens, 5);
        chk("ones_58", dig_ones, 8);
        chk("busy_continuous", bad, 0);
        chk("never_12", bad12, 0);

        // Blink with BLINK_CLKS=4.
        game_win = 1'b1;
        ticks(1);
        chk("win_tens", dig_tens, 4'hA);
        chk("win_ones", dig_ones, 4'hA);
        chk("win_blank0", blank, 0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("win_blink", blank, (k / 4) % 2);
        end
        game_lose = 1'b1;
        ticks(1);
        chk("lose_tens", dig_tens, 4'hE);
        chk("lose_ones", dig_ones, 4'hE);
        chk("lose_blank0", blank, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("lose_blink", blank, (k / 4) % 2);
        end
        game_win = 1'b0; game_lose = 1'b0;
        ticks(1);
        chk("back_tens", dig_tens, 5);
        chk("back_ones", dig_ones, 8);
        chk("back_blank", blank, 0);

        // Reset in the middle of a conversion.
        pulse(82);
        ticks(3);
        rst_l = 1'b0;
        ticks(1);
        chk("midrst_tens", dig_tens, 0);
        chk("midrst_ones", dig_ones, 0);
        chk("midrst_busy", busy, 0);
        rst_l = 1'b1;
        ticks(1);
        pulse(61);
        bad = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (dig_tens == 4'd8 && dig_ones == 4'd2) bad = 1'b1;
            if (t == 9) chk("tens_t9_zero", dig_tens, 0);
        end
        chk("tens_61", dig_tens, 6);
        chk("ones_61", dig_ones, 1);
        chk("no_82_leak", bad, 0);

        ticks(2);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
